instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/HighLevelControl.sv | 12 +
 rtl/instr_queue_ram.sv | 34 +++
 rtl/instr_fetch_queue.sv | 119 +++++++++++
 tb/tb_instr_fetch_queue.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/HighLevelControl.sv
// HighLevelControl: constants shared between the fetch, decode and
// register stages of the core.
//   NOP_INSTR          - canonical no-op (addi x0, x0, 0) driven on empty buses
//   DEFAULT_WORD_SIZE  - default instruction word width
//   DEFAULT_XLEN       - default architectural register / PC width
package HighLevelControl;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam int          DEFAULT_WORD_SIZE = 32;
  localparam int          DEFAULT_XLEN      = 32;

endpackage

// File: rtl/instr_queue_ram.sv
// instr_queue_ram: entry storage for the instruction fetch queue.
// DEPTH x WIDTH array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset; the
// owning queue's Count decides which entries are meaningful.
// Ports:
//   clk    - write clock
//   we     - write enable, sampled on the rising edge
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address
//   rdata  - read data, combinational from raddr
module instr_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: decouples instruction fetch from the register stage.
// First-word fall-through FIFO of {instruction, PC} pairs; the head entry
// is presented combinationally, but a word pushed on edge N only becomes
// visible after edge N (no bypass when empty).
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   FlushF              - redirect: drop everything queued, suppress push/pop
//   InValid/InReady     - push handshake from fetch (InReady = not full)
//   InInstr, InPC       - pushed instruction and its PC
//   OutValid/OutReady   - pop handshake to register stage (OutValid = not empty)
//   OutInstr, OutPC     - head entry, NOP/0 when empty
//   OutPCPlus4          - OutPC + 4 modulo 2^XLEN, 0 when empty
//   Count               - occupied entries, 0..DEPTH
module instr_fetch_queue
  import HighLevelControl::*;
#(
  parameter int DEPTH     = 4,
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int XLEN      = DEFAULT_XLEN
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     FlushF,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [WORD_SIZE-1:0]     InInstr,
  input  logic [XLEN-1:0]          InPC,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [WORD_SIZE-1:0]     OutInstr,
  output logic [XLEN-1:0]          OutPC,
  output logic [XLEN-1:0]          OutPCPlus4,
  output logic [$clog2(DEPTH):0]   Count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = WORD_SIZE + XLEN;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head_entry;
  logic [WORD_SIZE-1:0] head_instr;
  logic [XLEN-1:0]      head_pc;

  // InReady is purely a function of occupancy, so a full queue never
  // accepts a word even when the head is being consumed the same cycle.
  assign InReady  = (count_q < FULL_COUNT);
  assign OutValid = (count_q != '0);
  assign Count    = count_q;

  // Handshakes and next-state for the pointers and occupancy. A flush
  // wins over everything: pointers restart at zero and the push/pop that
  // would otherwise have happened is dropped. DEPTH is a power of two so
  // the pointer increments wrap naturally.
  always_comb begin
    push    = InValid && InReady && !FlushF;
    pop     = OutValid && OutReady && !FlushF;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (FlushF) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; storage itself lives in the RAM and
  // is left alone by reset since Count already marks it all empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  instr_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail_q),
    .wdata ({InInstr, InPC}),
    .raddr (head_q),
    .rdata (head_entry)
  );

  assign {head_instr, head_pc} = head_entry;

  // Stale RAM contents must never leak downstream, so an empty queue
  // presents a NOP at PC 0.
  assign OutInstr   = OutValid ? head_instr : WORD_SIZE'(NOP_INSTR);
  assign OutPC      = OutValid ? head_pc : '0;
  assign OutPCPlus4 = OutValid ? (head_pc + XLEN'(4)) : '0;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed bench for instr_fetch_queue (DEPTH=4,
// 32-bit words and PCs). Stimulus pushes the words it expects to be stored
// into a scoreboard queue; a monitor pops and compares the head whenever
// the DUT completes a pop handshake. Occupancy and empty-queue outputs are
// checked directly against hand-computed values.
module tb_instr_fetch_queue;

  logic        clk;
  logic        reset;
  logic        FlushF;
  logic        InValid;
  logic        InReady;
  logic [31:0] InInstr;
  logic [31:0] InPC;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] OutInstr;
  logic [31:0] OutPC;
  logic [31:0] OutPCPlus4;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  // Expected entries in push order, {instr, pc}.
  logic [63:0] sbQ [$];

  instr_fetch_queue #(
    .DEPTH     (4),
    .WORD_SIZE (32),
    .XLEN      (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .FlushF     (FlushF),
    .InValid    (InValid),
    .InReady    (InReady),
    .InInstr    (InInstr),
    .InPC       (InPC),
    .OutValid   (OutValid),
    .OutReady   (OutReady),
    .OutInstr   (OutInstr),
    .OutPC      (OutPC),
    .OutPCPlus4 (OutPCPlus4),
    .Count      (Count)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point shared by the stimulus and the monitor.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of inputs starting just after a rising edge and
  // returns just after the next one. Words the DUT should accept are
  // recorded in the scoreboard; a flush empties it.
  task automatic applyStimulus(input logic v, input logic [31:0] instr,
                               input logic [31:0] pc, input logic rdy,
                               input logic fl, input logic expectPush);
    InValid  = v;
    InInstr  = instr;
    InPC     = pc;
    OutReady = rdy;
    FlushF   = fl;
    if (expectPush) sbQ.push_back({instr, pc});
    if (fl) sbQ.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, " Count"},      32'(Count), 32'd0);
    checkOutput({tag, " OutValid"},   32'(OutValid), 32'd0);
    checkOutput({tag, " InReady"},    32'(InReady), 32'd1);
    checkOutput({tag, " OutInstr"},   OutInstr, 32'h0000_0013);
    checkOutput({tag, " OutPC"},      OutPC, 32'd0);
    checkOutput({tag, " OutPCPlus4"}, OutPCPlus4, 32'd0);
  endtask

  // Monitor: on every completed pop handshake the head must be the oldest
  // expected entry, with PC+4 wrapping at 32 bits.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (!reset && OutValid && OutReady && !FlushF) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected pop OutValid", 32'(OutValid), 32'd0);
        end else begin
          exp = sbQ.pop_front();
          checkOutput("pop OutInstr",   OutInstr, exp[63:32]);
          checkOutput("pop OutPC",      OutPC, exp[31:0]);
          checkOutput("pop OutPCPlus4", OutPCPlus4, exp[31:0] + 32'd4);
        end
      end
    end
  end

  // Watchdog so a broken run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    FlushF   = 1'b0;
    InValid  = 1'b0;
    InInstr  = '0;
    InPC     = '0;
    OutReady = 1'b0;
    #1;
    checkEmpty("in reset");
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkEmpty("after reset");

    // Two pushes with the register stage stalled.
    applyStimulus(1'b1, 32'h0050_0093, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0010_8113, 32'h4, 1'b0, 1'b0, 1'b1);
    checkOutput("two pushes Count",      32'(Count), 32'd2);
    checkOutput("two pushes OutInstr",   OutInstr, 32'h0050_0093);
    checkOutput("two pushes OutPC",      OutPC, 32'h0);
    checkOutput("two pushes OutPCPlus4", OutPCPlus4, 32'h4);

    // Fill to DEPTH, then keep presenting a fifth word.
    applyStimulus(1'b1, 32'h0020_0193, 32'h8, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h0030_0213, 32'hC, 1'b0, 1'b0, 1'b1);
    checkOutput("full Count",   32'(Count), 32'd4);
    checkOutput("full InReady", 32'(InReady), 32'd0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b0, 1'b0, 1'b0);
    checkOutput("held full Count",   32'(Count), 32'd4);
    checkOutput("held full InReady", 32'(InReady), 32'd0);

    // Pop while full with the fifth word still presented: pop only.
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h10, 1'b1, 1'b0, 1'b0);
    checkOutput("full pop+push Count", 32'(Count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    checkEmpty("drained");

    // Steady push+pop with two entries in flight across pointer wrap.
    applyStimulus(1'b1, 32'h1000_0000, 32'h100, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h1000_0001, 32'h104, 1'b0, 1'b0, 1'b1);
    for (int i = 2; i < 12; i++) begin
      applyStimulus(1'b1, 32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i),
                    1'b1, 1'b0, 1'b1);
      checkOutput($sformatf("stream %0d Count", i), 32'(Count), 32'd2);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkEmpty("stream drained");
    checkOutput("stream scoreboard empty", 32'(sbQ.size()), 32'd0);

    // Push while empty with OutReady high; PC at the top of the space.
    applyStimulus(1'b1, 32'h1234_5678, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1);
    checkOutput("empty push Count", 32'(Count), 32'd1);
    checkOutput("wrap OutPCPlus4",  OutPCPlus4, 32'h0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("wrap drained Count", 32'(Count), 32'd0);

    // Flush with a push and a pop presented at the same time.
    applyStimulus(1'b1, 32'h2000_0000, 32'h200, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h2000_0001, 32'h204, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h2000_0002, 32'h208, 1'b0, 1'b0, 1'b1);
    checkOutput("pre-flush Count", 32'(Count), 32'd3);
    applyStimulus(1'b1, 32'hBAD0_BAD0, 32'h20C, 1'b1, 1'b1, 1'b0);
    checkEmpty("flushed");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkOutput("post-flush Count", 32'(Count), 32'd0);

    // Asynchronous reset in the middle of a cycle with three entries.
    applyStimulus(1'b1, 32'h3000_0000, 32'h300, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h3000_0001, 32'h304, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h3000_0002, 32'h308, 1'b0, 1'b0, 1'b1);
    InValid = 1'b0;
    checkOutput("pre-reset Count", 32'(Count), 32'd3);
    #2;
    reset = 1'b1;
    sbQ.delete();
    #1;
    checkEmpty("async reset");
    #2;
    reset = 1'b0;

    // First push after reset lands on the very next edge.
    applyStimulus(1'b1, 32'h4000_0000, 32'h400, 1'b0, 1'b0, 1'b1);
    checkOutput("post-reset push Count",    32'(Count), 32'd1);
    checkOutput("post-reset push OutInstr", OutInstr, 32'h4000_0000);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkEmpty("final");
    checkOutput("final scoreboard empty", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
